// File: rtl/mac_arbiter.sv
// Round-robin burst arbiter: grants one vector FIFO for BURST_LEN beats and
// forwards each popped vector through a single tagged output register.
module mac_arbiter #(
  parameter int WORD_L    = 8,
  parameter int PORT_L    = 8,
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 4,
  parameter int ID_L      = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_REQ-1:0][PORT_L-1:0][WORD_L-1:0] req_data,
  input  logic [NUM_REQ-1:0]                       req_vld,
  output logic [NUM_REQ-1:0]                       req_rdy,
  output logic [PORT_L-1:0][WORD_L-1:0]            out_data,
  output logic                                     out_vld,
  output logic [ID_L-1:0]                          out_id,
  output logic                                     out_last,
  input  logic                                     mac_rdy
);
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                     state_q, state_d;
  logic [ID_L-1:0]            gnt_q, gnt_d, ptr_q, ptr_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [PORT_L-1:0][WORD_L-1:0] data_q, data_d;
  logic                       vld_q, vld_d, last_q, last_d;
  logic [ID_L-1:0]            id_q, id_d;

  logic                       slot_free, xfer, last_beat, found;
  logic [ID_L-1:0]            pick, idx;

  // First valid requester at or after ptr, scanning cyclically.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_L'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req_vld[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // req_rdy depends only on state and the output slot, never on req_vld.
  always_comb begin
    slot_free = !vld_q || mac_rdy;
    req_rdy   = '0;
    if (state_q == BURST) req_rdy[gnt_q] = slot_free;
    xfer      = (state_q == BURST) && slot_free && req_vld[gnt_q];
    last_beat = (cnt_q == CNT_W'(BURST_LEN - 1));
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    vld_d   = vld_q;
    id_d    = id_q;
    last_d  = last_q;
    if (vld_q && mac_rdy) vld_d = 1'b0;
    if (state_q == IDLE) begin
      if (found) begin
        gnt_d   = pick;
        cnt_d   = '0;
        state_d = BURST;
      end
    end else if (xfer) begin
      data_d = req_data[gnt_q];
      id_d   = gnt_q;
      last_d = last_beat;
      vld_d  = 1'b1;
      if (last_beat) begin
        state_d = IDLE;
        ptr_d   = (gnt_q == ID_L'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      id_q    <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign out_data = data_q;
  assign out_vld  = vld_q;
  assign out_id   = id_q;
  assign out_last = last_q;

endmodule

// File: tb/tb_mac_arbiter.sv
// Randomized and directed bench for mac_arbiter against a burst-level model
// with per-source scoreboards.
module tb_mac_arbiter;
  localparam int WORD_L = 8, PORT_L = 8, NUM_REQ = 4, BURST_LEN = 4, ID_L = 2;
  typedef logic [PORT_L-1:0][WORD_L-1:0] vec_t;

  logic clk, rst, mac_rdy, out_vld, out_last;
  logic [NUM_REQ-1:0][PORT_L-1:0][WORD_L-1:0] req_data;
  logic [NUM_REQ-1:0] req_vld, req_rdy;
  vec_t out_data;
  logic [ID_L-1:0] out_id;

  mac_arbiter #(.WORD_L(WORD_L), .PORT_L(PORT_L), .NUM_REQ(NUM_REQ),
                .BURST_LEN(BURST_LEN), .ID_L(ID_L)) dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_vld(req_vld),
    .req_rdy(req_rdy), .out_data(out_data), .out_vld(out_vld),
    .out_id(out_id), .out_last(out_last), .mac_rdy(mac_rdy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int seq [NUM_REQ];
  vec_t sbq [NUM_REQ][$];

  // Model: who owns the port, how many beats it has delivered, where the
  // next scan starts, and what the MAC should be seeing.
  bit   m_busy, m_ovld, m_olast;
  int   m_gnt, m_done, m_ptr, m_oid;
  vec_t m_odata;

  int cyc;
  logic [63:0] rdy_hist, last_hist;
  int last_ids[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic vec_t mkvec(input int i, input int s);
    vec_t v;
    for (int w = 0; w < PORT_L; w++) v[w] = WORD_L'(s * 29 + i * 71 + w * 13);
    v[0] = WORD_L'(s);
    v[1] = WORD_L'(i);
    return v;
  endfunction

  function automatic logic [NUM_REQ-1:0] m_rdy();
    logic [NUM_REQ-1:0] r = '0;
    if (m_busy && (!m_ovld || mac_rdy)) r[m_gnt] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_ovld = 0; m_olast = 0;
    m_gnt = 0; m_done = 0; m_ptr = 0; m_oid = 0; m_odata = '0;
    for (int i = 0; i < NUM_REQ; i++) sbq[i].delete();
  endtask

  task automatic model_edge();
    logic [NUM_REQ-1:0] r = m_rdy();
    bit pop = m_busy && r[m_gnt] && req_vld[m_gnt];
    if (m_ovld && mac_rdy) m_ovld = 0;
    if (!m_busy) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int j = (m_ptr + k) % NUM_REQ;
        if (req_vld[j]) begin
          m_gnt = j; m_done = 0; m_busy = 1;
          break;
        end
      end
    end else if (pop) begin
      m_odata = req_data[m_gnt];
      m_oid   = m_gnt;
      m_ovld  = 1;
      sbq[m_gnt].push_back(req_data[m_gnt]);
      seq[m_gnt]++;
      m_done++;
      m_olast = (m_done == BURST_LEN);
      if (m_done == BURST_LEN) begin
        m_busy = 0;
        m_ptr  = (m_gnt + 1) % NUM_REQ;
      end
    end
  endtask

  // One clock: drive FIFO heads, compare everything, advance model.
  task automatic step();
    int id;
    for (int i = 0; i < NUM_REQ; i++) req_data[i] = mkvec(i, seq[i]);
    #1;
    chk("req_rdy", req_rdy, m_rdy());
    chk("out_vld", out_vld, m_ovld);
    if (m_ovld) begin
      chk("out_data", out_data, m_odata);
      chk("out_id", out_id, m_oid);
      chk("out_last", out_last, m_olast);
    end
    if (out_vld && mac_rdy) begin
      id = int'(out_id);
      chk("sb_avail", (id < NUM_REQ) && (sbq[id].size() > 0), 1);
      if (id < NUM_REQ && sbq[id].size() > 0) chk("sb_data", out_data, sbq[id].pop_front());
      if (out_last) last_ids.push_back(id);
    end
    if (cyc < 64) begin
      rdy_hist[cyc]  = req_rdy[2];
      last_hist[cyc] = out_vld && out_last;
    end
    cyc++;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_out_vld", out_vld, 0);
    chk("rst_req_rdy", req_rdy, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0; rdy_hist = '0; last_hist = '0;
    last_ids.delete();
  endtask

  initial begin
    vec_t held;
    int exp_ord [5] = '{0, 1, 2, 3, 0};
    rst = 1'b1; mac_rdy = 1'b0; req_vld = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      seq[i] = 0;
      req_data[i] = mkvec(i, 0);
    end
    model_reset();
    @(negedge clk);
    do_reset();
    chk("rst_out_data", out_data, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_out_last", out_last, 0);

    // Single source with re-grant after one bubble.
    req_vld = 4'b0100; mac_rdy = 1'b1;
    repeat (11) step();
    chk("single_rdy_pattern", rdy_hist[10:0], 11'b01111011110);
    chk("single_last_pattern", last_hist[10:0], 11'b10000100000);

    // Fairness from ptr=0.
    do_reset();
    req_vld = 4'b1111; mac_rdy = 1'b1;
    repeat (26) step();
    chk("fair_nbursts", last_ids.size(), 5);
    for (int b = 0; b < 5 && b < last_ids.size(); b++) chk("fair_order", last_ids[b], exp_ord[b]);

    // Reset mid-burst, then restart from req0.
    do_reset();
    req_vld = 4'b0100;
    repeat (3) step();
    do_reset();
    req_vld = 4'b1111;
    repeat (2) step();
    chk("post_rst_vld", out_vld, 1);
    chk("post_rst_id", out_id, 0);

    // Backpressure holds the output register and blocks pops.
    do_reset();
    req_vld = 4'b1111; mac_rdy = 1'b1;
    repeat (2) step();
    held = out_data;
    mac_rdy = 1'b0;
    repeat (3) step();
    chk("bp_hold_data", out_data, held);
    chk("bp_rdy_low", req_rdy, 0);
    mac_rdy = 1'b1;
    repeat (30) step();

    // Hole in burst: no preemption by req1.
    do_reset();
    req_vld = 4'b0011;
    repeat (3) step();
    req_vld = 4'b0010;
    for (int h = 0; h < 5; h++) begin
      step();
      chk("hole_no_rdy1", req_rdy[1], 0);
    end
    req_vld = 4'b0011;
    repeat (3) step();
    chk("hole_then_req1", req_rdy, 4'b0010);

    // Wrap: ptr=3 after a burst from req2.
    do_reset();
    req_vld = 4'b0100;
    repeat (5) step();
    req_vld = 4'b1010;
    step();
    chk("wrap_grant3", req_rdy, 4'b1000);
    repeat (5) step();
    chk("wrap_grant1", req_rdy, 4'b0010);

    // Randomized traffic and backpressure.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_REQ; i++) req_vld[i] = ($urandom_range(0, 9) < 7);
      mac_rdy = ($urandom_range(0, 3) != 0);
      step();
    end
    mac_rdy = 1'b1; req_vld = '0;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
